// File: rtl/bist_march_ctrl.sv
// March C- memory BIST controller: sequences the six elements over 0..ADDR_LIMIT,
// compares read data and reports each newly failing repair block once.
module bist_march_ctrl #(
  parameter int BLOCK_SHIFT     = 7,
  parameter int MAX_FAULT_BLOCK = 25
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        START,
  input  logic [15:0] ADDR_LIMIT,
  output logic [15:0] MEM_ADDR,
  output logic        MEM_CE,
  output logic        MEM_CSB,
  output logic        MEM_WEB,
  output logic        MEM_OEB,
  output logic [7:0]  MEM_IDATA,
  input  logic [7:0]  MEM_ODATA,
  output logic        BIST_EN,
  output logic        FAULT_VALID,
  output logic [15:0] FAULT_ADDR,
  output logic        BUSY,
  output logic        DONE,
  output logic        ANY_FAULT,
  output logic        REPAIR_OVF,
  output logic [2:0]  DBG_STATE
);
  localparam int         BLK_W   = 16 - BLOCK_SHIFT;
  localparam int         NBLK    = 1 << BLK_W;
  localparam logic [4:0] MAX_CNT = 5'(MAX_FAULT_BLOCK);

  typedef enum logic [2:0] {ST_IDLE, ST_WR, ST_RD, ST_CMP, ST_DONE} state_t;

  state_t            state, state_n;
  logic [2:0]        elem, elem_n;
  logic              op, op_n;
  logic [15:0]       addr, addr_n, lim;
  logic [NBLK-1:0]   reported;
  logic [4:0]        fault_cnt;
  logic [BLK_W-1:0]  blk;
  logic              mismatch, op_end, down, at_final;

  function automatic logic op_is_read(input logic [2:0] e, input logic o);
    return (e == 3'd5) || ((e != 3'd0) && !o);
  endfunction

  function automatic logic op_is_last(input logic [2:0] e, input logic o);
    return (e == 3'd0) || (e == 3'd5) || o;
  endfunction

  // All-ones data: writes of M1/M3, reads of M2/M4; everything else is all-zeros.
  function automatic logic [7:0] op_pattern(input logic [2:0] e, input logic o);
    logic one;
    if (op_is_read(e, o)) one = (e == 3'd2) || (e == 3'd4);
    else                  one = (e == 3'd1) || (e == 3'd3);
    return one ? 8'hFF : 8'h00;
  endfunction

  assign down      = (elem >= 3'd3);
  assign at_final  = down ? (addr == 16'd0) : (addr == lim);
  assign blk       = addr[15:BLOCK_SHIFT];
  assign mismatch  = (state == ST_CMP) && (MEM_ODATA != op_pattern(elem, op));
  assign MEM_ADDR  = addr;
  assign DBG_STATE = state;

  always_comb begin
    state_n = state;
    elem_n  = elem;
    op_n    = op;
    addr_n  = addr;
    op_end  = 1'b0;
    case (state)
      ST_IDLE: if (START) begin
        state_n = ST_WR;
        elem_n  = 3'd0;
        op_n    = 1'b0;
        addr_n  = 16'd0;
      end
      ST_WR:   op_end  = 1'b1;
      ST_RD:   state_n = ST_CMP;
      ST_CMP:  op_end  = 1'b1;
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
    if (op_end) begin
      if (!op_is_last(elem, op)) begin
        op_n    = 1'b1;
        state_n = op_is_read(elem, 1'b1) ? ST_RD : ST_WR;
      end else if (!at_final) begin
        addr_n  = down ? addr - 16'd1 : addr + 16'd1;
        op_n    = 1'b0;
        state_n = op_is_read(elem, 1'b0) ? ST_RD : ST_WR;
      end else if (elem == 3'd5) begin
        state_n = ST_DONE;
      end else begin
        // Element boundary: up elements restart at 0, down elements at the limit.
        elem_n  = elem + 3'd1;
        op_n    = 1'b0;
        addr_n  = (elem_n >= 3'd3) ? lim : 16'd0;
        state_n = op_is_read(elem_n, 1'b0) ? ST_RD : ST_WR;
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state <= ST_IDLE;
      elem  <= 3'd0;
      op    <= 1'b0;
      addr  <= 16'd0;
      lim   <= 16'd0;
    end else begin
      state <= state_n;
      elem  <= elem_n;
      op    <= op_n;
      addr  <= addr_n;
      if (state == ST_IDLE && START) lim <= ADDR_LIMIT;
    end
  end

  // Strobes are registered from the next state so they line up with the state.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      MEM_CE    <= 1'b0;
      MEM_CSB   <= 1'b1;
      MEM_WEB   <= 1'b1;
      MEM_OEB   <= 1'b1;
      MEM_IDATA <= 8'h00;
      BUSY      <= 1'b0;
      BIST_EN   <= 1'b0;
      DONE      <= 1'b0;
    end else begin
      MEM_CE    <= (state_n == ST_WR) || (state_n == ST_RD);
      MEM_CSB   <= !((state_n == ST_WR) || (state_n == ST_RD));
      MEM_WEB   <= (state_n != ST_WR);
      MEM_OEB   <= (state_n != ST_RD);
      MEM_IDATA <= (state_n == ST_WR) ? op_pattern(elem_n, op_n) : 8'h00;
      BUSY      <= (state_n != ST_IDLE);
      BIST_EN   <= (state_n != ST_IDLE);
      DONE      <= (state_n == ST_DONE);
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      FAULT_VALID <= 1'b0;
      FAULT_ADDR  <= 16'd0;
      ANY_FAULT   <= 1'b0;
      REPAIR_OVF  <= 1'b0;
      reported    <= '0;
      fault_cnt   <= 5'd0;
    end else begin
      FAULT_VALID <= 1'b0;
      if (state == ST_IDLE && START) begin
        ANY_FAULT  <= 1'b0;
        REPAIR_OVF <= 1'b0;
        reported   <= '0;
        fault_cnt  <= 5'd0;
      end else if (mismatch) begin
        ANY_FAULT <= 1'b1;
        if (!reported[blk]) begin
          if (fault_cnt < MAX_CNT) begin
            FAULT_VALID   <= 1'b1;
            FAULT_ADDR    <= addr;
            reported[blk] <= 1'b1;
            fault_cnt     <= fault_cnt + 5'd1;
          end else begin
            REPAIR_OVF <= 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_bist_march_ctrl.sv
// Bench for bist_march_ctrl: faulty-memory model plus an operation-level March C-
// reference that predicts every fault report, its cycle, and the run length.
module tb_bist_march_ctrl;
  logic        CLK, RSTN, START;
  logic [15:0] ADDR_LIMIT;
  logic [15:0] MEM_ADDR;
  logic        MEM_CE, MEM_CSB, MEM_WEB, MEM_OEB;
  logic [7:0]  MEM_IDATA;
  logic [7:0]  MEM_ODATA = 8'h00;
  logic        BIST_EN, FAULT_VALID;
  logic [15:0] FAULT_ADDR;
  logic        BUSY, DONE, ANY_FAULT, REPAIR_OVF;
  logic [2:0]  DBG_STATE;

  bist_march_ctrl dut (
    .CLK(CLK), .RSTN(RSTN), .START(START), .ADDR_LIMIT(ADDR_LIMIT),
    .MEM_ADDR(MEM_ADDR), .MEM_CE(MEM_CE), .MEM_CSB(MEM_CSB), .MEM_WEB(MEM_WEB),
    .MEM_OEB(MEM_OEB), .MEM_IDATA(MEM_IDATA), .MEM_ODATA(MEM_ODATA),
    .BIST_EN(BIST_EN), .FAULT_VALID(FAULT_VALID), .FAULT_ADDR(FAULT_ADDR),
    .BUSY(BUSY), .DONE(DONE), .ANY_FAULT(ANY_FAULT), .REPAIR_OVF(REPAIR_OVF),
    .DBG_STATE(DBG_STATE)
  );

  // Clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  localparam logic [52:0] RST_OUTS = {16'h0, 4'b0111, 8'h00, 2'b00, 16'h0, 4'b0000, 3'd0};

  int n_cmp = 0;
  int n_bad = 0;

  // Memory with stuck-at masks and one optional "fails on 5th read" address
  logic [7:0] mem  [65536];
  logic [7:0] mm   [65536];
  logic [7:0] sa0m [65536];
  logic [7:0] sa1m [65536];
  int late_addr = -1;
  int late_cnt  = 0;

  function automatic logic [7:0] faulty(input logic [15:0] a, input logic [7:0] d);
    return (d | sa1m[a]) & ~sa0m[a];
  endfunction

  always @(posedge CLK) begin
    if (START) late_cnt <= 0;
    if (!MEM_CSB && !MEM_WEB) mem[MEM_ADDR] <= faulty(MEM_ADDR, MEM_IDATA);
    if (!MEM_CSB && !MEM_OEB) begin
      MEM_ODATA <= faulty(MEM_ADDR, mem[MEM_ADDR]) ^
                   ((int'(MEM_ADDR) == late_addr && late_cnt == 4) ? 8'h01 : 8'h00);
      if (int'(MEM_ADDR) == late_addr) late_cnt <= late_cnt + 1;
    end
  end

  // Reference model / scoreboard: {cycle[15:0], fault_addr[15:0]}
  logic [31:0] exp_q[$];
  logic        exp_any, exp_ovf;
  int          m_t, m_cnt, m_late;
  bit          m_rep [512];

  task automatic m_op(input int a, input bit is_rd, input logic [7:0] d);
    logic [7:0] got;
    int blk;
    if (!is_rd) begin
      mm[a] = faulty(16'(a), d);
      m_t += 1;
    end else begin
      m_t += 2;
      got = mm[a] ^ ((a == late_addr && m_late == 4) ? 8'h01 : 8'h00);
      if (a == late_addr) m_late++;
      if (got !== d) begin
        exp_any = 1'b1;
        blk = a >> 7;
        if (!m_rep[blk]) begin
          if (m_cnt < 25) begin
            m_rep[blk] = 1'b1;
            m_cnt++;
            exp_q.push_back({16'(m_t + 1), 16'(a)});
          end else begin
            exp_ovf = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic model_run(input int limit);
    int a;
    exp_q.delete();
    exp_any = 1'b0; exp_ovf = 1'b0;
    m_t = 0; m_cnt = 0; m_late = 0;
    for (int b = 0; b < 512; b++) m_rep[b] = 1'b0;
    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i <= limit; i++) begin
        a = (e < 3) ? i : limit - i;
        case (e)
          0: m_op(a, 1'b0, 8'h00);
          1: begin m_op(a, 1'b1, 8'h00); m_op(a, 1'b0, 8'hFF); end
          2: begin m_op(a, 1'b1, 8'hFF); m_op(a, 1'b0, 8'h00); end
          3: begin m_op(a, 1'b1, 8'h00); m_op(a, 1'b0, 8'hFF); end
          4: begin m_op(a, 1'b1, 8'hFF); m_op(a, 1'b0, 8'h00); end
          default: m_op(a, 1'b1, 8'h00);
        endcase
      end
    end
  endtask

  task automatic clear_faults();
    for (int i = 0; i < 65536; i++) begin
      sa0m[i] = 8'h00;
      sa1m[i] = 8'h00;
    end
    late_addr = -1;
  endtask

  function automatic logic [52:0] outs();
    return {MEM_ADDR, MEM_CE, MEM_CSB, MEM_WEB, MEM_OEB, MEM_IDATA, BIST_EN, FAULT_VALID,
            FAULT_ADDR, BUSY, DONE, ANY_FAULT, REPAIR_OVF, DBG_STATE};
  endfunction

  // Driver + monitor for one complete run; restart_cyc>0 pulses START mid-run.
  task automatic run_march(input string name, input int limit, input int restart_cyc);
    int cyc, busy_n, done_n, done_at, exp_total;
    bit fv_prev, consec, addr_oob, timeout;
    logic [31:0] got_q[$];
    logic [31:0] e, g;
    logic [27:0] s1, s3;
    logic [19:0] s2;
    model_run(limit);
    exp_total = 15 * (limit + 1) + 1;
    ADDR_LIMIT = 16'(limit);
    @(negedge CLK);
    START = 1'b1;
    cyc = 0; busy_n = 0; done_n = 0; done_at = 0;
    fv_prev = 0; consec = 0; addr_oob = 0; timeout = 1;
    s1 = '0; s2 = '0; s3 = '0;
    while (cyc < exp_total + 40) begin
      @(negedge CLK);
      cyc++;
      START = (cyc == restart_cyc);
      if (BUSY) busy_n++;
      if (DONE) begin done_n++; done_at = cyc; end
      if (FAULT_VALID) begin
        got_q.push_back({16'(cyc), FAULT_ADDR});
        if (fv_prev) consec = 1;
      end
      fv_prev = FAULT_VALID;
      if (int'(MEM_ADDR) > limit) addr_oob = 1;
      if (cyc == 1) s1 = {MEM_CE, MEM_CSB, MEM_WEB, MEM_OEB, MEM_IDATA, MEM_ADDR};
      if (cyc == 2) s2 = {MEM_CE, MEM_CSB, MEM_WEB, MEM_OEB, MEM_ADDR};
      if (cyc == limit + 4) s3 = {MEM_CE, MEM_CSB, MEM_WEB, MEM_OEB, MEM_IDATA, MEM_ADDR};
      if (!BUSY) begin timeout = 0; break; end
    end
    START = 1'b0;

    n_cmp++;
    if (timeout) begin
      n_bad++; $display("FAIL %s timeout: still busy after %0d cycles", name, cyc);
    end
    n_cmp++;
    if (busy_n !== exp_total) begin
      n_bad++; $display("FAIL %s busy_cycles: got %0d expected %0d", name, busy_n, exp_total);
    end
    n_cmp++;
    if (done_n !== 1 || done_at !== exp_total) begin
      n_bad++;
      $display("FAIL %s done_pulse: got %0d pulses last at %0d expected 1 at %0d",
               name, done_n, done_at, exp_total);
    end
    n_cmp++;
    if (s1 !== {4'b1001, 8'h00, 16'h0}) begin
      n_bad++; $display("FAIL %s first_write: got %h expected %h", name, s1, {4'b1001, 8'h00, 16'h0});
    end
    n_cmp++;
    if (s2 !== ((limit > 0) ? {4'b1001, 16'h1} : {4'b1010, 16'h0})) begin
      n_bad++; $display("FAIL %s second_op: got %h", name, s2);
    end
    n_cmp++;
    if (s3 !== {4'b1001, 8'hFF, 16'h0}) begin
      n_bad++; $display("FAIL %s m1_write1: got %h expected %h", name, s3, {4'b1001, 8'hFF, 16'h0});
    end
    n_cmp++;
    if (got_q.size() !== exp_q.size()) begin
      n_bad++;
      $display("FAIL %s fault_count: got %0d expected %0d", name, got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 32'hFFFF_FFFF;
      n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL %s fault_report: got cycle %0d addr %h expected cycle %0d addr %h",
                 name, g[31:16], g[15:0], e[31:16], e[15:0]);
      end
    end
    n_cmp++;
    if (consec || addr_oob) begin
      n_bad++; $display("FAIL %s fv_consec/addr_bound: got %0d/%0d expected 0/0", name, consec, addr_oob);
    end
    n_cmp++;
    if ({ANY_FAULT, REPAIR_OVF} !== {exp_any, exp_ovf}) begin
      n_bad++;
      $display("FAIL %s flags: got any=%b ovf=%b expected any=%b ovf=%b",
               name, ANY_FAULT, REPAIR_OVF, exp_any, exp_ovf);
    end
    repeat (3) @(negedge CLK);
    n_cmp++;
    if ({ANY_FAULT, REPAIR_OVF, MEM_CE, MEM_CSB, MEM_WEB, MEM_OEB, BUSY} !==
        {exp_any, exp_ovf, 4'b0111, 1'b0}) begin
      n_bad++;
      $display("FAIL %s idle_hold: got any=%b ovf=%b strobes=%b busy=%b", name,
               ANY_FAULT, REPAIR_OVF, {MEM_CE, MEM_CSB, MEM_WEB, MEM_OEB}, BUSY);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge CLK);
    n_cmp++;
    if (outs() !== RST_OUTS) begin
      n_bad++; $display("FAIL reset_values: got %h expected %h", outs(), RST_OUTS);
    end
    RSTN = 1'b1;
    repeat (3) @(negedge CLK);
    n_cmp++;
    if ({BUSY, BIST_EN, DONE} !== 3'b000) begin
      n_bad++; $display("FAIL idle_no_start: got %b expected 000", {BUSY, BIST_EN, DONE});
    end
  endtask

  task automatic test_fault_free();
    clear_faults();
    run_march("fault_free", 3, 0);
  endtask

  task automatic test_bound();
    clear_faults();
    run_march("bound_limit0", 0, 0);
  endtask

  task automatic test_single_fault();
    clear_faults();
    sa1m[16'h0085] = 8'h01;
    run_march("single_fault", 16'h00FF, 0);
  endtask

  task automatic test_dedup();
    clear_faults();
    sa0m[16'h0101] = 8'h80;
    sa0m[16'h0150] = 8'h04;
    run_march("dedup", 16'h0150, 0);
  endtask

  task automatic test_overflow();
    clear_faults();
    for (int b = 0; b < 26; b++) sa1m[b * 128 + 5] = 8'h01;
    run_march("overflow", 16'h0D7F, 0);
  endtask

  task automatic test_back_to_back_start();
    clear_faults();
    run_march("start_while_busy", 3, 10);
  endtask

  task automatic test_late_fault();
    clear_faults();
    late_addr = 0;
    run_march("fault_in_done", 0, 0);
  endtask

  task automatic test_random();
    int limit, nf, a;
    for (int it = 0; it < 3; it++) begin
      clear_faults();
      limit = $urandom_range(1, 300);
      nf = $urandom_range(0, 4);
      for (int k = 0; k < nf; k++) begin
        a = $urandom_range(0, limit);
        if ($urandom_range(0, 1) == 1) sa1m[a] = sa1m[a] | 8'(1 << $urandom_range(0, 7));
        else                           sa0m[a] = sa0m[a] | 8'(1 << $urandom_range(0, 7));
      end
      run_march($sformatf("random%0d", it), limit, 0);
    end
  endtask

  task automatic test_reset_mid();
    bit saw_done;
    clear_faults();
    sa1m[1] = 8'h01;
    ADDR_LIMIT = 16'd10;
    saw_done = 0;
    @(negedge CLK);
    START = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge CLK);
      START = 1'b0;
      if (DONE) saw_done = 1;
    end
    n_cmp++;
    if ({ANY_FAULT, FAULT_ADDR, BUSY} !== {1'b1, 16'h0001, 1'b1}) begin
      n_bad++; $display("FAIL mid_run_state: got any=%b addr=%h busy=%b expected 1/0001/1",
                        ANY_FAULT, FAULT_ADDR, BUSY);
    end
    RSTN = 1'b0;
    #1;
    n_cmp++;
    if (outs() !== RST_OUTS) begin
      n_bad++; $display("FAIL mid_reset_values: got %h expected %h", outs(), RST_OUTS);
    end
    @(negedge CLK);
    RSTN = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      if (DONE || BUSY) saw_done = 1;
    end
    n_cmp++;
    if (saw_done !== 1'b0) begin
      n_bad++; $display("FAIL mid_reset_abort: got done/busy activity %b expected 0", saw_done);
    end
  endtask

  initial begin
    RSTN = 1'b0;
    START = 1'b0;
    ADDR_LIMIT = 16'd0;
    clear_faults();
    test_reset();
    test_fault_free();
    test_bound();
    test_single_fault();
    test_dedup();
    test_overflow();
    test_back_to_back_start();
    test_late_fault();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
